// File: rtl/vec_alu_seq.sv
// Issue/collect sequencer for the lane-parallel vector ALU: reads sources from the VRF,
// runs all lanes until every lane reports done, then OR-merges the lane results into vd.
module vec_alu_seq #(
    parameter int unsigned VLEN     = 128,
    parameter int unsigned NB_LANES = 2,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [5:0]                      cmd_opcode,
    input  logic [2:0]                      cmd_op_type,
    input  logic [2:0]                      cmd_vsew,
    input  logic [4:0]                      cmd_vd,
    input  logic [4:0]                      cmd_vs1,
    input  logic [4:0]                      cmd_vs2,
    input  logic [63:0]                     cmd_rs1_data,
    input  logic [4:0]                      cmd_imm,
    output logic                            vrf_ren,
    output logic [4:0]                      vrf_raddr,
    input  logic [VLEN-1:0]                 vrf_rdata,
    output logic                            vrf_wen,
    output logic [4:0]                      vrf_waddr,
    output logic [VLEN-1:0]                 vrf_wdata,
    output logic                            lane_run,
    output logic [1:0]                      lane_nb_lanes,
    output logic [5:0]                      lane_opcode,
    output logic [2:0]                      lane_op_type,
    output logic [2:0]                      lane_vsew,
    output logic [VLEN-1:0]                 lane_vs1,
    output logic [VLEN-1:0]                 lane_vs2,
    input  logic [(1<<NB_LANES)-1:0]        lane_done,
    input  logic [VLEN*(1<<NB_LANES)-1:0]   lane_vd,
    output logic                            resp_valid,
    output logic                            err
);

    localparam int unsigned NLANES = 1 << NB_LANES;
    localparam int unsigned CW     = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OPT_VV = 3'b001;
    localparam logic [2:0] OPT_VX = 3'b010;
    localparam logic [2:0] OPT_VI = 3'b100;

    typedef enum logic [2:0] {IDLE, RD_VS2, RD_VS1, EXEC, WB} state_t;

    state_t          state, state_n;
    logic [4:0]      vd_q, vd_n;
    logic [4:0]      vs1_idx_q, vs1_idx_n;
    logic [63:0]     rs1_q, rs1_n;
    logic [4:0]      imm_q, imm_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [5:0]      opcode_n;
    logic [2:0]      op_type_n, vsew_n;
    logic [VLEN-1:0] vs1_n, vs2_n, wdata_n, merged_c;
    logic            cmd_ready_n, lane_run_n, wen_n, resp_n, err_n;
    logic            cmd_legal_c, all_done_c;

    assign lane_nb_lanes = 2'(NB_LANES);
    assign vrf_waddr     = vd_q;
    assign all_done_c    = &lane_done;

    assign cmd_legal_c = ((cmd_opcode == 6'b000000) || (cmd_opcode == 6'b001001) ||
                          (cmd_opcode == 6'b001010) || (cmd_opcode == 6'b001011)) &&
                         ((cmd_op_type == OPT_VV) || (cmd_op_type == OPT_VX) ||
                          (cmd_op_type == OPT_VI)) &&
                         !cmd_vsew[2];

    // Replicate the low SEW bits of a scalar across the whole vector.
    function automatic logic [VLEN-1:0] splat(input logic [63:0] val, input logic [1:0] sew);
        case (sew)
            2'd0:    splat = {(VLEN/8){val[7:0]}};
            2'd1:    splat = {(VLEN/16){val[15:0]}};
            2'd2:    splat = {(VLEN/32){val[31:0]}};
            default: splat = {(VLEN/64){val}};
        endcase
    endfunction

    // Lanes hold zero outside their own elements, so OR is the merge.
    always_comb begin
        merged_c = '0;
        for (int i = 0; i < NLANES; i++) begin
            merged_c = merged_c | lane_vd[i*VLEN +: VLEN];
        end
    end

    // Next-state and output decode. The read strobe is combinational so data returns in the next state.
    always_comb begin
        state_n     = state;
        vd_n        = vd_q;
        vs1_idx_n   = vs1_idx_q;
        rs1_n       = rs1_q;
        imm_n       = imm_q;
        opcode_n    = lane_opcode;
        op_type_n   = lane_op_type;
        vsew_n      = lane_vsew;
        vs1_n       = lane_vs1;
        vs2_n       = lane_vs2;
        wdata_n     = vrf_wdata;
        cnt_n       = '0;
        wen_n       = 1'b0;
        resp_n      = 1'b0;
        err_n       = 1'b0;
        vrf_ren     = 1'b0;
        vrf_raddr   = '0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    opcode_n  = cmd_opcode;
                    op_type_n = cmd_op_type;
                    vsew_n    = cmd_vsew;
                    vd_n      = cmd_vd;
                    vs1_idx_n = cmd_vs1;
                    rs1_n     = cmd_rs1_data;
                    imm_n     = cmd_imm;
                    if (cmd_legal_c) begin
                        vrf_ren   = resetn;
                        vrf_raddr = cmd_vs2;
                        state_n   = RD_VS2;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RD_VS2: begin
                vs2_n = vrf_rdata;
                case (lane_op_type)
                    OPT_VV: begin
                        vrf_ren   = 1'b1;
                        vrf_raddr = vs1_idx_q;
                        state_n   = RD_VS1;
                    end
                    OPT_VX: begin
                        vs1_n   = splat(rs1_q, lane_vsew[1:0]);
                        state_n = EXEC;
                    end
                    OPT_VI: begin
                        vs1_n   = splat({{59{imm_q[4]}}, imm_q}, lane_vsew[1:0]);
                        state_n = EXEC;
                    end
                    default: state_n = IDLE;
                endcase
            end
            RD_VS1: begin
                vs1_n   = vrf_rdata;
                state_n = EXEC;
            end
            EXEC: begin
                if (all_done_c) begin
                    wdata_n = merged_c;
                    wen_n   = 1'b1;
                    resp_n  = 1'b1;
                    state_n = WB;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WB: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        cmd_ready_n = (state_n == IDLE);
        lane_run_n  = (state_n == EXEC);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            lane_run     <= 1'b0;
            vrf_wen      <= 1'b0;
            resp_valid   <= 1'b0;
            err          <= 1'b0;
            vrf_wdata    <= '0;
            lane_opcode  <= '0;
            lane_op_type <= '0;
            lane_vsew    <= '0;
            lane_vs1     <= '0;
            lane_vs2     <= '0;
            vd_q         <= '0;
            vs1_idx_q    <= '0;
            rs1_q        <= '0;
            imm_q        <= '0;
            cnt          <= '0;
        end else begin
            state        <= state_n;
            cmd_ready    <= cmd_ready_n;
            lane_run     <= lane_run_n;
            vrf_wen      <= wen_n;
            resp_valid   <= resp_n;
            err          <= err_n;
            vrf_wdata    <= wdata_n;
            lane_opcode  <= opcode_n;
            lane_op_type <= op_type_n;
            lane_vsew    <= vsew_n;
            lane_vs1     <= vs1_n;
            lane_vs2     <= vs2_n;
            vd_q         <= vd_n;
            vs1_idx_q    <= vs1_idx_n;
            rs1_q        <= rs1_n;
            imm_q        <= imm_n;
            cnt          <= cnt_n;
        end
    end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Scoreboard bench for vec_alu_seq with a behavioural VRF and four behavioural lanes.
module tb_vec_alu_seq;

    localparam int unsigned VLEN = 128;
    localparam int unsigned NBL  = 2;
    localparam int unsigned NL   = 4;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [5:0]           cmd_opcode;
    logic [2:0]           cmd_op_type;
    logic [2:0]           cmd_vsew;
    logic [4:0]           cmd_vd, cmd_vs1, cmd_vs2;
    logic [63:0]          cmd_rs1_data;
    logic [4:0]           cmd_imm;
    logic                 vrf_ren;
    logic [4:0]           vrf_raddr;
    logic [VLEN-1:0]      vrf_rdata;
    logic                 vrf_wen;
    logic [4:0]           vrf_waddr;
    logic [VLEN-1:0]      vrf_wdata;
    logic                 lane_run;
    logic [1:0]           lane_nb_lanes;
    logic [5:0]           lane_opcode;
    logic [2:0]           lane_op_type;
    logic [2:0]           lane_vsew;
    logic [VLEN-1:0]      lane_vs1, lane_vs2;
    logic [NL-1:0]        lane_done;
    logic [VLEN*NL-1:0]   lane_vd;
    logic                 resp_valid;
    logic                 err;

    vec_alu_seq #(.VLEN(VLEN), .NB_LANES(NBL), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_op_type(cmd_op_type), .cmd_vsew(cmd_vsew), .cmd_vd(cmd_vd),
        .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_rs1_data(cmd_rs1_data), .cmd_imm(cmd_imm),
        .vrf_ren(vrf_ren), .vrf_raddr(vrf_raddr), .vrf_rdata(vrf_rdata),
        .vrf_wen(vrf_wen), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
        .lane_run(lane_run), .lane_nb_lanes(lane_nb_lanes), .lane_opcode(lane_opcode),
        .lane_op_type(lane_op_type), .lane_vsew(lane_vsew), .lane_vs1(lane_vs1),
        .lane_vs2(lane_vs2), .lane_done(lane_done), .lane_vd(lane_vd),
        .resp_valid(resp_valid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            is_err;
        logic [4:0]      addr;
        logic [VLEN-1:0] data;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  n_cmp = 0;
    int  n_fail = 0;
    int  ren_cnt = 0;
    int  wen_cnt = 0;
    logic all_done_prev = 1'b0;

    task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural VRF: one-cycle read latency, plus a bench-side preload port.
    logic [VLEN-1:0] vrf [32];
    logic            pre_we = 1'b0;
    logic [4:0]      pre_addr = '0;
    logic [VLEN-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) vrf[pre_addr] <= pre_data;
        else if (vrf_wen) vrf[vrf_waddr] <= vrf_wdata;
        if (vrf_ren) vrf_rdata <= vrf[vrf_raddr];
    end

    // Behavioural lanes: lane i owns elements e with e%4 == i and finishes after a staggered delay.
    int  lane_dly [NL] = '{1, 3, 0, 2};
    int  lcnt [NL];
    bit  hold_lane2 = 1'b0;

    function automatic logic [VLEN-1:0] lane_calc(input int ln, input logic [5:0] op,
                                                   input logic [2:0] sew,
                                                   input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
        logic [VLEN-1:0] r;
        logic [63:0] ea, eb, er;
        int w, n;
        r = '0;
        w = 8 << sew;
        n = VLEN / w;
        for (int e = 0; e < n; e++) begin
            if (e % NL == ln) begin
                ea = '0;
                eb = '0;
                for (int k = 0; k < w; k++) begin
                    ea[k] = a[e*w + k];
                    eb[k] = b[e*w + k];
                end
                case (op)
                    6'b000000: er = ea + eb;
                    6'b001001: er = ea & eb;
                    6'b001010: er = ea | eb;
                    6'b001011: er = ea ^ eb;
                    default:   er = '0;
                endcase
                for (int k = 0; k < w; k++) r[e*w + k] = er[k];
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn || !lane_run) begin
            lane_done <= '0;
            lane_vd   <= '0;
            for (int i = 0; i < NL; i++) lcnt[i] <= 0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                lcnt[i] <= lcnt[i] + 1;
                if (lcnt[i] == lane_dly[i] && !(hold_lane2 && i == 2)) begin
                    lane_done[i]           <= 1'b1;
                    lane_vd[i*VLEN +: VLEN] <= lane_calc(i, lane_opcode, lane_vsew, lane_vs2, lane_vs1);
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every write-back or error pulse.
    always @(negedge clk) begin
        if (resetn) begin
            if (vrf_ren) ren_cnt++;
            if (vrf_wen) begin
                wen_cnt++;
                check("wb_after_all_done", all_done_prev, 1);
                check("resp_with_wen", resp_valid, 1);
                check("sb_nonempty_wb", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("wb_kind", mon_e.is_err, 0);
                    check("wb_addr", vrf_waddr, mon_e.addr);
                    check("wb_data", vrf_wdata, mon_e.data);
                end
            end else if (resp_valid) begin
                check("resp_without_wen", resp_valid, 0);
            end
            if (err) begin
                check("sb_nonempty_err", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("err_kind", mon_e.is_err, 1);
                end
            end
            all_done_prev = &lane_done;
        end
    end

    task automatic push_wb(input logic [4:0] a, input logic [VLEN-1:0] d);
        sb.push_back('{is_err: 1'b0, addr: a, data: d});
    endtask

    task automatic push_err();
        sb.push_back('{is_err: 1'b1, addr: '0, data: '0});
    endtask

    task automatic load(input logic [4:0] a, input logic [VLEN-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk); #1;
        pre_we   = 1'b0;
    endtask

    // Offers one command; for legal ones returns the cycle (accept = 0) in which lane_run first rises.
    task automatic issue(input logic [5:0] op, input logic [2:0] ty, input logic [2:0] sew,
                         input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [63:0] rs1, input logic [4:0] imm, input bit legal,
                         output int run_lat);
        int k;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!cmd_ready) check("ready_wait", cmd_ready, 1);
        cmd_opcode = op; cmd_op_type = ty; cmd_vsew = sew;
        cmd_vd = vd; cmd_vs1 = vs1; cmd_vs2 = vs2;
        cmd_rs1_data = rs1; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        run_lat = 0;
        if (legal) begin
            for (int j = 1; j < 100; j++) begin
                @(posedge clk); #1;
                if (lane_run) begin
                    run_lat = j + 1;
                    break;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(cmd_ready && !lane_run) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_reached", cmd_ready, 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, r0, w0, k;
        resetn = 1'b0;
        cmd_valid = 1'b0; cmd_opcode = '0; cmd_op_type = '0; cmd_vsew = '0;
        cmd_vd = '0; cmd_vs1 = '0; cmd_vs2 = '0; cmd_rs1_data = '0; cmd_imm = '0;
        @(posedge clk); #1;

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_lane_run", lane_run, 0);
        check("rst_vrf_wen", vrf_wen, 0);
        check("rst_err", err, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_nb_lanes", lane_nb_lanes, 2);

        load(5'd1, {16{8'h02}});
        load(5'd2, {16{8'h01}});
        load(5'd5, {32'd3, 32'd2, 32'd1, 32'd0});
        load(5'd7, {8{16'h0001}});
        load(5'd10, {16{8'hAA}});
        resetn = 1'b1;
        @(posedge clk); #1;

        // vadd VV SEW8 then back-to-back vand reading the freshly written v3
        r0 = ren_cnt;
        push_wb(5'd3, {16{8'h03}});
        issue(6'b000000, 3'b001, 3'd0, 5'd3, 5'd1, 5'd2, 64'd0, 5'd0, 1'b1, lat);
        check("vv_run_latency", lat, 3);
        push_wb(5'd4, {16{8'h02}});
        issue(6'b001001, 3'b001, 3'd0, 5'd4, 5'd1, 5'd3, 64'd0, 5'd0, 1'b1, lat);
        check("b2b_run_latency", lat, 3);
        wait_idle();
        check("vv_read_count", ren_cnt - r0, 4);

        // vxor VX SEW32: only the low 32 scalar bits are used, one VRF read
        r0 = ren_cnt;
        push_wb(5'd6, 128'hFFFFFFFC_FFFFFFFD_FFFFFFFE_FFFFFFFF);
        issue(6'b001011, 3'b010, 3'd2, 5'd6, 5'd0, 5'd5, 64'hDEADBEEF_FFFFFFFF, 5'd0, 1'b1, lat);
        check("vx_run_latency", lat, 2);
        wait_idle();
        check("vx_read_count", ren_cnt - r0, 1);

        // vadd VI SEW16, imm = -1, vd aliases vs2
        r0 = ren_cnt;
        push_wb(5'd7, '0);
        issue(6'b000000, 3'b100, 3'd1, 5'd7, 5'd0, 5'd7, 64'd0, 5'b11111, 1'b1, lat);
        check("vi_run_latency", lat, 2);
        check("vi_lane_vs1", lane_vs1, {8{16'hFFFF}});
        check("vi_lane_vs2", lane_vs2, {8{16'h0001}});
        wait_idle();
        check("vi_read_count", ren_cnt - r0, 1);

        // Illegal commands: bad vsew, bad op_type, unknown opcode
        r0 = ren_cnt;
        w0 = wen_cnt;
        push_err();
        issue(6'b000000, 3'b001, 3'd4, 5'd12, 5'd1, 5'd2, 64'd0, 5'd0, 1'b0, lat);
        check("ill_vsew_ready", cmd_ready, 1);
        wait_idle();
        push_err();
        issue(6'b000000, 3'b011, 3'd0, 5'd12, 5'd1, 5'd2, 64'd0, 5'd0, 1'b0, lat);
        check("ill_optype_ready", cmd_ready, 1);
        wait_idle();
        push_err();
        issue(6'b000001, 3'b001, 3'd0, 5'd12, 5'd1, 5'd2, 64'd0, 5'd0, 1'b0, lat);
        check("ill_opcode_ready", cmd_ready, 1);
        wait_idle();
        check("ill_no_reads", ren_cnt - r0, 0);
        check("ill_no_writes", wen_cnt - w0, 0);

        // Timeout: lane 2 never reports done
        w0 = wen_cnt;
        hold_lane2 = 1'b1;
        push_err();
        issue(6'b001010, 3'b001, 3'd0, 5'd9, 5'd1, 5'd2, 64'd0, 5'd0, 1'b1, lat);
        k = 0;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk); #1;
            if (err) begin
                k = j;
                break;
            end
        end
        check("timeout_exec_cycle", k, 16);
        check("timeout_lane_run", lane_run, 0);
        check("timeout_ready", cmd_ready, 1);
        hold_lane2 = 1'b0;
        wait_idle();
        check("timeout_no_write", wen_cnt - w0, 0);

        // Asynchronous reset in the middle of EXEC
        w0 = wen_cnt;
        issue(6'b001010, 3'b001, 3'd0, 5'd10, 5'd1, 5'd2, 64'd0, 5'd0, 1'b1, lat);
        check("rst_test_running", lane_run, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_lane_run", lane_run, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_vrf_wen", vrf_wen, 0);
        check("arst_err", err, 0);
        check("arst_lane_vs1", lane_vs1, '0);
        check("arst_vrf_wdata", vrf_wdata, '0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("arst_no_write", wen_cnt - w0, 0);
        check("arst_v10_kept", vrf[10], {16{8'hAA}});

        // Recovery after reset: vxor VX SEW64
        push_wb(5'd11, {2{64'h00224466_88AACCEE}});
        issue(6'b001011, 3'b010, 3'd3, 5'd11, 5'd0, 5'd2, 64'h01234567_89ABCDEF, 5'd0, 1'b1, lat);
        check("vx64_run_latency", lat, 2);
        wait_idle();

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
